// File: rtl/multiface_pkg.sv
// Shared types and snoop-layout offsets for the Multiface freeze controller.
// Snoop offsets are subtracted from the last shadow RAM address.
package multiface_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ACTIVE,
    HIDDEN,
    HIDDEN_OUT
  } mf_state_t;

  localparam int OFS_PEN_IDX  = 'h030;
  localparam int OFS_PEN0     = 'h06F;
  localparam int OFS_BORDER   = 'h020;
  localparam int OFS_MODE     = 'h010;
  localparam int OFS_BANK     = 'h000;
  localparam int OFS_CRTC_SEL = 'h300;
  localparam int OFS_CRTC0    = 'h24F;
  localparam int OFS_PPI      = 'h800;
  localparam int OFS_ROMSEL   = 'h553;

  localparam int CPU_WINDOW_BYTES = 8192;

endpackage

// File: rtl/multiface_shadow_ram.sv
// Single-port synchronous shadow RAM, read-first, one-cycle read latency.
// Contents are deliberately not reset so a frozen snapshot survives a CPU reset.
module multiface_shadow_ram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [0:(1 << AW) - 1];
  logic [7:0] rdata_q;

  // Write on demand and always register the addressed byte for the next cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    rdata_q <= mem[addr];
  end

  assign dout = rdata_q;

endmodule

// File: rtl/multiface_ctrl.sv
// Multiface-style freeze controller: NMI key handling, MF ROM/RAM paging at
// 0000-3FFF and snooping of Gate Array/CRTC/PPI/ROM-select writes into the
// top of shadow RAM. Optional key debounce is enabled by MF_NMI_DEBOUNCE_EN.
module multiface_ctrl
  import multiface_pkg::*;
#(
  parameter int          RAM_AW    = 13,
  parameter logic [8:0]  ROM_PAGE  = 9'h1FF,
  parameter logic [15:0] NMI_VEC   = 16'h0066,
  parameter logic [15:0] HIDE_VEC  = 16'h0065,
  parameter logic [15:0] CTRL_PORT = 16'hFEE8,
  parameter int          CRTC_REGS = 16,
  parameter int          DEB_W     = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        key_nmi,
  input  logic        m1,
  input  logic        io_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic        nmi,
  output logic        mf_en,
  output logic        mf_rom_en,
  output logic        mf_ram_en,
  output logic [22:0] rom_addr,
  output logic [7:0]  dout
);

  localparam int TOP = (1 << RAM_AW) - 1;

  localparam logic [RAM_AW-1:0] A_PEN_IDX  = RAM_AW'(TOP - OFS_PEN_IDX);
  localparam logic [RAM_AW-1:0] A_PEN0     = RAM_AW'(TOP - OFS_PEN0);
  localparam logic [RAM_AW-1:0] A_BORDER   = RAM_AW'(TOP - OFS_BORDER);
  localparam logic [RAM_AW-1:0] A_MODE     = RAM_AW'(TOP - OFS_MODE);
  localparam logic [RAM_AW-1:0] A_BANK     = RAM_AW'(TOP - OFS_BANK);
  localparam logic [RAM_AW-1:0] A_CRTC_SEL = RAM_AW'(TOP - OFS_CRTC_SEL);
  localparam logic [RAM_AW-1:0] A_CRTC0    = RAM_AW'(TOP - OFS_CRTC0);
  localparam logic [RAM_AW-1:0] A_PPI      = RAM_AW'(TOP - OFS_PPI);
  localparam logic [RAM_AW-1:0] A_ROMSEL   = RAM_AW'(TOP - OFS_ROMSEL);
  localparam logic [RAM_AW-1:0] CPU_BASE   = RAM_AW'((1 << RAM_AW) - CPU_WINDOW_BYTES);

  mf_state_t state_q, state_d;

  logic       m1_q, m1_d;
  logic       io_q, io_d;
  logic [4:0] pen_idx_q, pen_idx_d;
  logic [4:0] crtc_sel_q, crtc_sel_d;

  logic m1_rise, io_rise;
  logic ctrl_hit, ctrl_in, ctrl_out;
  logic key_acc;

  logic              snoop_we;
  logic [RAM_AW-1:0] snoop_addr;
  logic [RAM_AW-1:0] cpu_ram_addr;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_rdata;

`ifdef MF_NMI_DEBOUNCE_EN
  localparam logic [DEB_W:0] DEB_FULL = {1'b1, {DEB_W{1'b0}}};
  localparam logic [DEB_W:0] DEB_LAST = {1'b0, {DEB_W{1'b1}}};
  localparam logic [DEB_W:0] DEB_ONE  = {{DEB_W{1'b0}}, 1'b1};

  logic [DEB_W:0] deb_cnt_q, deb_cnt_d;

  // Count consecutive high samples; accept exactly once when the run reaches 2^DEB_W.
  always_comb begin
    key_acc   = key_nmi && (deb_cnt_q == DEB_LAST);
    deb_cnt_d = deb_cnt_q;
    if (!key_nmi) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_FULL) begin
      deb_cnt_d = deb_cnt_q + DEB_ONE;
    end
  end
`else
  logic key_q, key_d;

  if (DEB_W < 1) begin : g_deb_w_check
    $error("multiface_ctrl: DEB_W must be at least 1");
  end

  // Without debounce any raw rising edge of the key is taken.
  always_comb begin
    key_d   = key_nmi;
    key_acc = key_nmi && !key_q;
  end
`endif

  // Edge detection on M1 and I/O write, plus control-port decode.
  always_comb begin
    m1_d     = m1;
    io_d     = io_wr;
    m1_rise  = m1 && !m1_q;
    io_rise  = io_wr && !io_q;
    ctrl_hit = io_rise && (cpu_addr[15:2] == CTRL_PORT[15:2]);
    ctrl_in  = ctrl_hit && !cpu_addr[1];
    ctrl_out = ctrl_hit && cpu_addr[1];
  end

  // Map snooped port writes to their shadow RAM slots and track pen/CRTC selects.
  always_comb begin
    snoop_we   = 1'b0;
    snoop_addr = '0;
    pen_idx_d  = pen_idx_q;
    crtc_sel_d = crtc_sel_q;
    if (io_rise && !ctrl_hit) begin
      case (cpu_addr[15:8])
        8'h7F: begin
          snoop_we = 1'b1;
          case (cpu_dout[7:6])
            2'b00: begin
              snoop_addr = A_PEN_IDX;
              pen_idx_d  = cpu_dout[4:0];
            end
            2'b01:   snoop_addr = pen_idx_q[4] ? A_BORDER : A_PEN0 + RAM_AW'(pen_idx_q[3:0]);
            2'b10:   snoop_addr = A_MODE;
            default: snoop_addr = A_BANK;
          endcase
        end
        8'hBC: begin
          snoop_we   = 1'b1;
          snoop_addr = A_CRTC_SEL;
          crtc_sel_d = cpu_dout[4:0];
        end
        8'hBD: begin
          if ({27'b0, crtc_sel_q} < CRTC_REGS) begin
            snoop_we   = 1'b1;
            snoop_addr = A_CRTC0 + RAM_AW'(crtc_sel_q);
          end
        end
        8'hF7: begin
          snoop_we   = 1'b1;
          snoop_addr = A_PPI;
        end
        8'hDF: begin
          snoop_we   = 1'b1;
          snoop_addr = A_ROMSEL;
        end
        default: ;
      endcase
    end
  end

  // Freeze state machine: key -> pending NMI -> paged in -> hidden -> invisible.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrl_in) begin
          state_d = ACTIVE;
        end else if (key_acc) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (m1_rise && (cpu_addr == NMI_VEC)) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ctrl_out) begin
          state_d = IDLE;
        end else if (m1_rise && (cpu_addr == HIDE_VEC)) begin
          state_d = HIDDEN;
        end
      end
      HIDDEN: begin
        if (ctrl_out) begin
          state_d = HIDDEN_OUT;
        end
      end
      HIDDEN_OUT: state_d = HIDDEN_OUT;
      default:    state_d = IDLE;
    endcase
  end

  // Paging outputs; reset drops paging in the same cycle rather than at the next edge.
  always_comb begin
    nmi       = (state_q == PEND);
    mf_en     = ((state_q == ACTIVE) || (state_q == HIDDEN)) && !reset;
    mf_rom_en = mf_en && (cpu_addr[15:13] == 3'b000);
    mf_ram_en = mf_en && (cpu_addr[15:13] == 3'b001);
    rom_addr  = {ROM_PAGE, cpu_addr[13:0]};
  end

  // Shadow RAM port arbitration: snoop beats CPU write; otherwise the CPU address is read.
  always_comb begin
    cpu_ram_addr = CPU_BASE + RAM_AW'(cpu_addr[12:0]);
    ram_we       = 1'b0;
    ram_addr     = cpu_ram_addr;
    if (ctrl_hit) begin
      ram_we = 1'b0;
    end else if (snoop_we) begin
      ram_we   = 1'b1;
      ram_addr = snoop_addr;
    end else if (mem_wr && mf_ram_en) begin
      ram_we = 1'b1;
    end
    dout = (mf_ram_en && mem_rd) ? ram_rdata : 8'hFF;
  end

  // State, edge history and select registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      m1_q       <= 1'b0;
      io_q       <= 1'b0;
      pen_idx_q  <= '0;
      crtc_sel_q <= '0;
`ifdef MF_NMI_DEBOUNCE_EN
      deb_cnt_q  <= '0;
`else
      key_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      m1_q       <= m1_d;
      io_q       <= io_d;
      pen_idx_q  <= pen_idx_d;
      crtc_sel_q <= crtc_sel_d;
`ifdef MF_NMI_DEBOUNCE_EN
      deb_cnt_q  <= deb_cnt_d;
`else
      key_q      <= key_d;
`endif
    end
  end

  multiface_shadow_ram #(
    .AW(RAM_AW)
  ) u_shadow_ram (
    .clk  (clk_sys),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (cpu_dout),
    .dout (ram_rdata)
  );

endmodule

// File: tb/tb_multiface_ctrl.sv
// Testbench for multiface_ctrl (default RAM_AW=13 layout, DEB_W=4).
module tb_multiface_ctrl;

`ifdef MF_NMI_DEBOUNCE_EN
  localparam int KEY_MIN = 16;
`else
  localparam int KEY_MIN = 1;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        key_nmi;
  logic        m1;
  logic        io_wr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        nmi;
  logic        mf_en;
  logic        mf_rom_en;
  logic        mf_ram_en;
  logic [22:0] rom_addr;
  logic [7:0]  dout;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: behaviour flags, select registers and known shadow bytes.
  bit         pend_m, paged_m, hidden_m, gone_m;
  int         pen_m, crtc_m;
  logic [7:0] shadow [int];
  int         written [$];

  always #5 clk_sys = ~clk_sys;

  multiface_ctrl #(
    .RAM_AW    (13),
    .ROM_PAGE  (9'h1FF),
    .NMI_VEC   (16'h0066),
    .HIDE_VEC  (16'h0065),
    .CTRL_PORT (16'hFEE8),
    .CRTC_REGS (16),
    .DEB_W     (4)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .key_nmi   (key_nmi),
    .m1        (m1),
    .io_wr     (io_wr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .nmi       (nmi),
    .mf_en     (mf_en),
    .mf_rom_en (mf_rom_en),
    .mf_ram_en (mf_ram_en),
    .rom_addr  (rom_addr),
    .dout      (dout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pend_m = 0; paged_m = 0; hidden_m = 0; gone_m = 0;
    pen_m = 0; crtc_m = 0;
  endtask

  task automatic shadowPut(input int idx, input logic [7:0] d);
    shadow[idx] = d;
    written.push_back(idx);
  endtask

  task automatic modelIo(input logic [15:0] a, input logic [7:0] d);
    int t;
    t = 8191;
    if ((a & 16'hFFFC) == 16'hFEE8) begin
      if (a[1] == 1'b0) begin
        if (!pend_m && !paged_m && !gone_m) paged_m = 1;
      end else if (paged_m) begin
        if (hidden_m) gone_m = 1;
        paged_m = 0;
        hidden_m = 0;
      end
    end else begin
      case (a[15:8])
        8'h7F: begin
          if (d[7:6] == 2'd0) begin
            pen_m = int'(d[4:0]);
            shadowPut(t - 'h30, d);
          end else if (d[7:6] == 2'd1) begin
            if (pen_m >= 16) shadowPut(t - 'h20, d);
            else shadowPut(t - 'h6F + (pen_m % 16), d);
          end else if (d[7:6] == 2'd2) begin
            shadowPut(t - 'h10, d);
          end else begin
            shadowPut(t, d);
          end
        end
        8'hBC: begin
          crtc_m = int'(d[4:0]);
          shadowPut(t - 'h300, d);
        end
        8'hBD: if (crtc_m < 16) shadowPut(t - 'h24F + crtc_m, d);
        8'hF7: shadowPut(t - 'h800, d);
        8'hDF: shadowPut(t - 'h553, d);
        default: ;
      endcase
    end
  endtask

  // OUT instruction: one io_wr pulse, then a cycle low so the next pulse is a fresh edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    cpu_addr = a; cpu_dout = d; io_wr = 1'b1;
    @(negedge clk_sys);
    io_wr = 1'b0;
    modelIo(a, d);
  endtask

  task automatic m1Fetch(input logic [15:0] a);
    @(negedge clk_sys);
    cpu_addr = a; m1 = 1'b1;
    @(negedge clk_sys);
    m1 = 1'b0;
    if (pend_m && a == 16'h0066) begin
      pend_m = 0; paged_m = 1; hidden_m = 0;
    end else if (paged_m && !hidden_m && a == 16'h0065) begin
      hidden_m = 1;
    end
  endtask

  task automatic memWrite(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    cpu_addr = a; cpu_dout = d; mem_wr = 1'b1;
    @(negedge clk_sys);
    mem_wr = 1'b0;
    if (paged_m && a[15:13] == 3'b001) shadowPut(int'(a[12:0]), d);
  endtask

  task automatic readCheck(input string tag, input logic [15:0] a);
    int idx;
    @(negedge clk_sys);
    cpu_addr = a; mem_rd = 1'b1;
    @(negedge clk_sys);
    idx = int'(a[12:0]);
    if (paged_m && a[15:13] == 3'b001) begin
      if (shadow.exists(idx)) checkOutput(tag, 32'(dout), 32'(shadow[idx]));
    end else begin
      checkOutput(tag, 32'(dout), 32'hFF);
    end
    mem_rd = 1'b0;
  endtask

  task automatic pressKey(input int hold);
    @(negedge clk_sys);
    key_nmi = 1'b1;
    repeat (hold) @(negedge clk_sys);
    key_nmi = 1'b0;
    if (hold >= KEY_MIN && !pend_m && !paged_m && !gone_m) pend_m = 1;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          op;

    reset = 1'b1; key_nmi = 0; m1 = 0; io_wr = 0; mem_rd = 1; mem_wr = 0;
    cpu_addr = 16'h2000; cpu_dout = 8'h00;
    modelReset();
    repeat (3) @(negedge clk_sys);
    checkOutput("reset nmi", 32'(nmi), 32'(pend_m));
    checkOutput("reset mf_en", 32'(mf_en), 32'(paged_m));
    checkOutput("reset dout", 32'(dout), 32'hFF);
    reset = 1'b0; mem_rd = 1'b0;

    // NMI entry
    pressKey(KEY_MIN);
    checkOutput("nmi after key", 32'(nmi), 32'(pend_m));
    checkOutput("mf_en while pending", 32'(mf_en), 32'(paged_m));
    m1Fetch(16'h0066);
    checkOutput("nmi after ack", 32'(nmi), 32'(pend_m));
    checkOutput("mf_en after ack", 32'(mf_en), 32'(paged_m));
    @(negedge clk_sys);
    cpu_addr = 16'h0010;
    #1;
    checkOutput("mf_rom_en 0010", 32'(mf_rom_en), 32'd1);
    checkOutput("rom_addr 0010", 32'(rom_addr), 32'h7FC010);
    checkOutput("mf_ram_en 0010", 32'(mf_ram_en), 32'd0);

    // Gate Array snoop
    applyStimulus(16'h7F00, 8'h02);
    applyStimulus(16'h7F00, 8'h54);
    readCheck("pen index slot", 16'h3FCF);
    readCheck("pen 2 ink", 16'h3F92);
    applyStimulus(16'h7F00, 8'h10);
    applyStimulus(16'h7F00, 8'h44);
    readCheck("border ink", 16'h3FDF);

    // CRTC snoop, including an out-of-range register
    applyStimulus(16'hBC00, 8'h0C);
    applyStimulus(16'hBD00, 8'h30);
    readCheck("crtc select slot", 16'h3CFF);
    readCheck("crtc reg 12", 16'h3DBC);
    memWrite(16'h3DC4, 8'h5A);
    applyStimulus(16'hBC00, 8'h14);
    applyStimulus(16'hBD00, 8'h77);
    readCheck("crtc reg 20 not stored", 16'h3DC4);
    readCheck("crtc select 14", 16'h3CFF);

    // CPU access to the shadow RAM window
    memWrite(16'h2100, 8'hA5);
    readCheck("cpu ram 2100", 16'h2100);
    #1;
    checkOutput("mf_ram_en 2100", 32'(mf_ram_en), 32'(paged_m));
    readCheck("outside window 4100", 16'h4100);
    checkOutput("mf_ram_en 4100", 32'(mf_ram_en), 32'd0);

    // Randomized traffic while paged in
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 7);
      d  = 8'($urandom_range(0, 255));
      case (op)
        0: applyStimulus(16'h7F00 | 16'($urandom_range(0, 255)), d);
        1: applyStimulus(16'hBC00 | 16'($urandom_range(0, 255)), d);
        2: applyStimulus(16'hBD00 | 16'($urandom_range(0, 255)), d);
        3: begin
          case ($urandom_range(0, 2))
            0:       a = 16'hF700;
            1:       a = 16'hDF00;
            default: a = 16'h1200;
          endcase
          applyStimulus(a | 16'($urandom_range(0, 255)), d);
        end
        4: memWrite(16'h2000 + 16'($urandom_range(0, 8191)), d);
        5: begin
          if (written.size() > 0)
            readCheck("random read", 16'h2000 + 16'(written[$urandom_range(0, written.size() - 1)]));
        end
        6: begin
          a = 16'($urandom_range(0, 16383));
          @(negedge clk_sys);
          cpu_addr = a;
          #1;
          checkOutput("random mf_rom_en", 32'(mf_rom_en), 32'(paged_m && (a < 16'h2000)));
          checkOutput("random rom_addr", 32'(rom_addr), 32'('h1FF * 16384 + (int'(a) % 16384)));
        end
        default: begin
          pressKey(KEY_MIN);
          checkOutput("key ignored while paged", 32'(nmi), 32'(pend_m));
        end
      endcase
    end
    checkOutput("mf_en after random", 32'(mf_en), 32'(paged_m));

    // Page out and back in
    applyStimulus(16'hFEEA, 8'h00);
    checkOutput("mf_en page out", 32'(mf_en), 32'(paged_m));
    readCheck("read after page out", 16'h2100);
    applyStimulus(16'hFEE8, 8'h00);
    checkOutput("mf_en page in", 32'(mf_en), 32'(paged_m));

    // Hidden mode
    m1Fetch(16'h0065);
    checkOutput("mf_en hidden", 32'(mf_en), 32'(paged_m));
    applyStimulus(16'hFEEA, 8'h00);
    checkOutput("mf_en hidden out", 32'(mf_en), 32'(paged_m));
    applyStimulus(16'hFEE8, 8'h00);
    checkOutput("mf_en page in ignored", 32'(mf_en), 32'(paged_m));
    pressKey(KEY_MIN);
    checkOutput("nmi while invisible", 32'(nmi), 32'(pend_m));

    // Reset while NMI pending
    @(negedge clk_sys); reset = 1'b1;
    @(negedge clk_sys); reset = 1'b0; modelReset();
    pressKey(KEY_MIN);
    checkOutput("nmi after reset", 32'(nmi), 32'(pend_m));
    @(negedge clk_sys); reset = 1'b1;
    @(negedge clk_sys); modelReset();
    checkOutput("nmi cleared by reset", 32'(nmi), 32'(pend_m));
    reset = 1'b0;

    // Select registers cleared by reset
    applyStimulus(16'hFEE8, 8'h00);
    checkOutput("mf_en page in from idle", 32'(mf_en), 32'(paged_m));
    applyStimulus(16'h7F00, 8'h47);
    readCheck("pen 0 after reset", 16'h3F90);
    applyStimulus(16'hBD00, 8'h9C);
    readCheck("crtc reg 0 after reset", 16'h3DB0);

    // Reset releases paging in the same cycle
    @(negedge clk_sys); reset = 1'b1;
    #1;
    checkOutput("mf_en during reset", 32'(mf_en), 32'd0);
    @(negedge clk_sys); reset = 1'b0; modelReset();
    checkOutput("mf_en after reset", 32'(mf_en), 32'(paged_m));

    // Short and long key presses
    pressKey(10);
    checkOutput("nmi after 10-clk press", 32'(nmi), 32'(pend_m));
    repeat (2) @(negedge clk_sys);
    pressKey(16);
    checkOutput("nmi after 16-clk press", 32'(nmi), 32'(pend_m));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
